// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone bus arbiters.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ERR   = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Ceiling log2, never less than 1 so derived vectors always have a bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/wb_sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', with wrap.
module rr_pick
   import wb_arb_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   logic [IW-1:0] idx;

   // Scan last+1 .. last+N, wrapping by explicit compare so non-power-of-two N works.
   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      idx     = last_i;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx == IW'(N - 1)) idx = '0;
         else                   idx = idx + IW'(1);
         if (!valid_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter sharing one SDRAM controller port between N
// masters, holding grant for a whole cycle, with a per-access watchdog.
module wb_sdram_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [N-1:0]       m_cyc_i,
   input  logic [N-1:0]       m_stb_i,
   input  logic [N-1:0]       m_we_i,
   input  logic [N*AW-1:0]    m_adr_i,
   input  logic [N*DW-1:0]    m_dat_i,
   input  logic [N*DW/8-1:0]  m_sel_i,
   input  logic [N*3-1:0]     m_cti_i,
   input  logic [N*2-1:0]     m_bte_i,
   output logic [DW-1:0]      m_dat_o,
   output logic [N-1:0]       m_ack_o,
   output logic [N-1:0]       m_err_o,
   output logic               s_cyc_o,
   output logic               s_stb_o,
   output logic               s_we_o,
   output logic [AW-1:0]      s_adr_o,
   output logic [DW-1:0]      s_dat_o,
   output logic [DW/8-1:0]    s_sel_o,
   output logic [2:0]         s_cti_o,
   output logic [1:0]         s_bte_o,
   input  logic [DW-1:0]      s_dat_i,
   input  logic               s_ack_i,
   input  logic               s_err_i,
   output logic [N-1:0]       grant_o,
   output logic               timeout_o
);

   localparam int unsigned IW      = clog2(N);
   localparam int unsigned CW      = clog2(TIMEOUT + 1);
   localparam int unsigned SW      = DW / 8;
   localparam bit          WD_EN   = (TIMEOUT > 0);
   localparam logic [CW-1:0] WD_LAST = WD_EN ? CW'(TIMEOUT - 1) : '0;

   arb_state_e    state_q;
   logic [N-1:0]  grant_q;
   logic [IW-1:0] gidx_q;
   logic [IW-1:0] last_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          timeout_q;

   logic [N-1:0]  pick_gnt;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          wd_inc;
   logic          wd_fire;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req_i   (m_cyc_i),
      .last_i  (last_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   // One-hot pick to index for the output mux.
   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pick_gnt[i]) pick_idx = IW'(i);
      end
   end

   // Route the owner's request to the slave and the slave's response to the owner.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_cti_o = '0;
      s_bte_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      if (state_q == BUSY) begin
         s_cyc_o = m_cyc_i[gidx_q];
         s_stb_o = m_stb_i[gidx_q];
         s_we_o  = m_we_i[gidx_q];
         s_adr_o = m_adr_i[gidx_q*AW +: AW];
         s_dat_o = m_dat_i[gidx_q*DW +: DW];
         s_sel_o = m_sel_i[gidx_q*SW +: SW];
         s_cti_o = m_cti_i[gidx_q*3 +: 3];
         s_bte_o = m_bte_i[gidx_q*2 +: 2];
         m_ack_o = grant_q & {N{s_ack_i}};
         m_err_o = grant_q & {N{s_err_i}};
      end else if (state_q == ERR) begin
         m_err_o = grant_q;
      end
   end

   // Watchdog: count stalled strobe cycles; an ack in the expiry cycle wins.
   always_comb begin
      wd_inc  = WD_EN && (state_q == BUSY) && s_stb_o && !s_ack_i && !s_err_i;
      wd_fire = wd_inc && (cnt_q == WD_LAST);
      if (wd_inc) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
      else        cnt_d = '0;
   end

   // Arbitration FSM with registered grant and timeout pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         last_q    <= IW'(N - 1);
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (pick_valid) begin
                  grant_q <= pick_gnt;
                  gidx_q  <= pick_idx;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!m_cyc_i[gidx_q]) begin
                  last_q  <= gidx_q;
                  grant_q <= '0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (wd_fire) begin
                  cnt_q     <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= ERR;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ERR: begin
               cnt_q   <= '0;
               state_q <= DRAIN;
            end
            DRAIN: begin
               cnt_q <= '0;
               if (!m_cyc_i[gidx_q]) begin
                  last_q  <= gidx_q;
                  grant_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant_o   = grant_q;
   assign timeout_o = timeout_q;
   assign m_dat_o   = s_dat_i;

endmodule

// File: doc/wb_sdram_arbiter.md
Name: wb_sdram_arbiter

Overview:
- Round-robin Wishbone B3 arbiter that shares the single SDRAM controller slave port between N masters: OR1200 instruction bus, OR1200 data bus, and the JTAG debug bus.
- Holds the grant for a master's whole cycle, covering bursts and locked read-modify-write sequences.
- A per-access watchdog converts a hung slave into a Wishbone error, so the CPU and the debug interface cannot deadlock on SDRAM.

Parameters:
- N, 3, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width (select width = DW/8).
- TIMEOUT, 1024, max cycles of stb with no ack/err before an error is forced; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- m_cyc_i, m_stb_i, m_we_i  in  N each  per-master Wishbone controls
- m_adr_i  in  N*AW  packed, master k at [k*AW +: AW]
- m_dat_i  in  N*DW  packed write data
- m_sel_i  in  N*DW/8  packed byte selects
- m_cti_i  in  N*3  cycle type ids
- m_bte_i  in  N*2  burst type ext
- m_dat_o  out  DW  slave read data, broadcast to all masters
- m_ack_o, m_err_o  out  N each  per-master ack / error
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to SDRAM controller
- s_adr_o  out  AW
- s_dat_o  out  DW
- s_sel_o  out  DW/8
- s_cti_o  out  3
- s_bte_o  out  2
- s_dat_i  in  DW
- s_ack_i, s_err_i  in  1 each
- grant_o  out  N  one-hot current owner; 0 when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values: state IDLE; grant_o=0; last=N-1 so master 0 has first priority; watchdog counter=0; timeout_o=0.
- Reset values, combinational outputs: all s_* outputs 0; m_ack_o=0; m_err_o=0. Reset mid-cycle aborts immediately; the slave sees cyc drop.
- State IDLE:
  - s_cyc_o/s_stb_o=0.
  - If any m_cyc_i is set, pick the first requester scanning (last+1) mod N upward with wrap.
  - Register its one-hot value in grant_o and go to BUSY.
  - Arbitration latency is one cycle, from the cycle m_cyc_i is high to the cycle s_cyc_o is high.
- State BUSY:
  - s_* outputs are a combinational mux of the granted master's inputs.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i; every non-granted ack/err is 0.
  - While m_cyc_i[g]=1 the grant holds, even when stb drops (RMW lock, burst gaps).
  - When m_cyc_i[g]=0: set last=g, clear grant_o, go to IDLE. One idle cycle always separates owners.
- Watchdog, active only if TIMEOUT>0:
  - The counter increments in BUSY when s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - It clears on ack, on err, on stb low, and on leaving BUSY.
  - When the counter reaches TIMEOUT-1 with no ack that cycle, go to ERR.
  - Simultaneous ack and expiry: ack wins, counter clears, no error.
- State ERR, exactly one cycle:
  - m_err_o[g]=1, timeout_o=1, s_cyc_o=s_stb_o=0.
  - The controller's late ack/err is discarded.
  - Next state is DRAIN.
- State DRAIN:
  - s_cyc_o=0; all ack/err discarded.
  - Wait for m_cyc_i[g]=0, then set last=g and go to IDLE.
- Width rules: the counter is clog2(TIMEOUT+1) bits and saturating; the grant index is clog2(N) bits; the wrap uses an explicit compare against N-1, never a power-of-two mask.
- m_dat_o=s_dat_i unconditionally; masters qualify it with their ack.

Decomposition:
- Shared package wb_arb_pkg holds:
  - the state enum (IDLE, BUSY, ERR, DRAIN);
  - the CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111);
  - the clog2 function.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the request vector and last; outputs are a one-hot grant and valid. It is reused by the planned UART/SPI bus arbiters.

Test Plan:
- Single master 1, classic read of 0x0000_0100; slave acks on the 3rd cycle. Required: s_cyc_o rises one cycle after m_cyc_i[1]; m_ack_o[1] pulses; grant_o=3'b010; back to IDLE one cycle after cyc drops.
- Masters 0, 1 and 2 all request continuously from reset. Required: grant order 0,1,2,0,1; one idle cycle between owners; no ack ever reaches a non-owner.
- Master 0 runs a 4-beat INCR burst (cti 010,010,010,111) while master 2 requests. Required: master 2 is not granted until master 0's cyc drops; all four acks reach master 0.
- TIMEOUT=16 and the slave never acks. Required: m_err_o[g] and timeout_o pulse exactly 16 cycles after stb rises, s_cyc_o drops the same cycle, and the slave's ack at cycle 20 is not forwarded.
- Expiry and ack coincide: ack on cycle 15 with TIMEOUT=16. Required: ack is forwarded, no err, timeout_o=0.
- rst_n_i asserted mid-burst. Required: s_cyc_o, grant_o and m_ack_o are 0 asynchronously; after release, master 0 has priority.
